// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction loader: opcodes, formats, FSM states, field layout.
// The optional opcode legality check is enabled by defining INSTR_LOADER_CHECK_EN.
package instr_loader_pkg;

  localparam int unsigned OPC_W   = 5;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned IMM_W   = 17;
  localparam int unsigned TGT_W   = 27;
  localparam int unsigned INSTR_W = 32;

  // Least-significant bit of each field inside the 32-bit instruction word
  localparam int unsigned OPC_LSB   = 27;
  localparam int unsigned RD_LSB    = 22;
  localparam int unsigned RS_LSB    = 17;
  localparam int unsigned RT_LSB    = 12;
  localparam int unsigned SHAMT_LSB = 7;
  localparam int unsigned ALUOP_LSB = 2;

  localparam logic [OPC_W-1:0] OP_ALU  = 5'b00000;
  localparam logic [OPC_W-1:0] OP_ADDI = 5'b00101;
  localparam logic [OPC_W-1:0] OP_SW   = 5'b00111;
  localparam logic [OPC_W-1:0] OP_LW   = 5'b01000;
  localparam logic [OPC_W-1:0] OP_BNE  = 5'b00010;
  localparam logic [OPC_W-1:0] OP_BLT  = 5'b00110;
  localparam logic [OPC_W-1:0] OP_J    = 5'b00001;
  localparam logic [OPC_W-1:0] OP_JAL  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_JR   = 5'b00100;
  localparam logic [OPC_W-1:0] OP_BEX  = 5'b10110;
  localparam logic [OPC_W-1:0] OP_SETX = 5'b10101;

  typedef enum logic [1:0] {FMT_R, FMT_I, FMT_JI, FMT_JII} fmt_e;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE, ST_ERR} state_e;

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] shamt;
    logic [REG_W-1:0] aluop;
    logic [IMM_W-1:0] imm;
    logic [TGT_W-1:0] target;
  } fields_t;

  // Unlisted opcodes fall back to the JI layout
  function automatic fmt_e op_format(input logic [OPC_W-1:0] op);
    case (op)
      OP_ALU:                                  return FMT_R;
      OP_ADDI, OP_SW, OP_LW, OP_BNE, OP_BLT:   return FMT_I;
      OP_JR:                                   return FMT_JII;
      default:                                 return FMT_JI;
    endcase
  endfunction

  function automatic logic op_legal(input logic [OPC_W-1:0] op);
    case (op)
      OP_ALU, OP_ADDI, OP_SW, OP_LW, OP_BNE, OP_BLT,
      OP_J, OP_JAL, OP_JR, OP_BEX, OP_SETX:    return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_loader_encoder.sv
// Combinational encoder: opcode plus operand fields to a 32-bit R/I/JI/JII word.
// With INSTR_LOADER_CHECK_EN defined it also flags opcodes outside the supported set.
module instr_encoder
  import instr_loader_pkg::*;
(
  input  fields_t              fields,
  output logic [INSTR_W-1:0]   word
`ifdef INSTR_LOADER_CHECK_EN
  ,
  output logic                 illegal
`endif
);

  always_comb begin
    word = '0;
    word[OPC_LSB +: OPC_W] = fields.opcode;
    case (op_format(fields.opcode))
      FMT_R: begin
        word[RD_LSB    +: REG_W] = fields.rd;
        word[RS_LSB    +: REG_W] = fields.rs;
        word[RT_LSB    +: REG_W] = fields.rt;
        word[SHAMT_LSB +: REG_W] = fields.shamt;
        word[ALUOP_LSB +: REG_W] = fields.aluop;
      end
      FMT_I: begin
        word[RD_LSB +: REG_W] = fields.rd;
        word[RS_LSB +: REG_W] = fields.rs;
        word[0      +: IMM_W] = fields.imm;
      end
      FMT_JII: word[RD_LSB +: REG_W] = fields.rd;
      default: word[0 +: TGT_W] = fields.target;
    endcase
  end

`ifdef INSTR_LOADER_CHECK_EN
  assign illegal = ~op_legal(fields.opcode);
`endif

endmodule

// File: rtl/instr_loader.sv
// Boot-time instruction loader: accepts field bundles, encodes them and writes imem sequentially
// while holding the CPU in reset. Define INSTR_LOADER_CHECK_EN to reject unsupported opcodes.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPC_W-1:0]    in_opcode,
  input  logic [REG_W-1:0]    in_rd,
  input  logic [REG_W-1:0]    in_rs,
  input  logic [REG_W-1:0]    in_rt,
  input  logic [REG_W-1:0]    in_shamt,
  input  logic [REG_W-1:0]    in_aluop,
  input  logic [IMM_W-1:0]    in_imm,
  input  logic [TGT_W-1:0]    in_target,
  input  logic                in_last,
  output logic                imem_we,
  output logic [ADDR_W-1:0]   imem_addr,
  output logic [INSTR_W-1:0]  imem_data,
  output logic                cpu_hold,
  output logic                load_done,
  output logic [ADDR_W:0]     load_count,
  output logic                err_overflow
`ifdef INSTR_LOADER_CHECK_EN
  ,
  output logic                err_illegal
`endif
);

  localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

  state_e               state, state_n;
  fields_t              fld;
  logic [INSTR_W-1:0]   enc_word;
  logic                 accept, restart;
  logic                 we_q, we_n, ready_n, hold_n, done_n, ovf_n;
  logic [ADDR_W-1:0]    addr_n;
  logic [INSTR_W-1:0]   data_n;
  logic [ADDR_W:0]      count_n;
`ifdef INSTR_LOADER_CHECK_EN
  logic                 enc_illegal, ill_n;
`endif

  assign fld = {in_opcode, in_rd, in_rs, in_rt, in_shamt, in_aluop, in_imm, in_target};

  instr_encoder u_enc (
    .fields  (fld),
    .word    (enc_word)
`ifdef INSTR_LOADER_CHECK_EN
    ,
    .illegal (enc_illegal)
`endif
  );

  assign accept = in_valid & in_ready;

  // A reset landing in the write cycle drops that pending write
  assign imem_we = we_q & ~reset;

  // Next-state and next-output logic
  always_comb begin
    state_n = state;
    we_n    = 1'b0;
    addr_n  = imem_addr;
    data_n  = imem_data;
    hold_n  = cpu_hold;
    done_n  = load_done;
    count_n = load_count;
    ovf_n   = err_overflow;
    restart = 1'b0;
`ifdef INSTR_LOADER_CHECK_EN
    ill_n   = err_illegal;
`endif
    unique case (state)
      ST_IDLE: begin
        hold_n  = ~load_done;
        restart = start;
      end
      ST_LOAD: begin
        if (accept) begin
          if (load_count == CAPACITY) begin
            ovf_n   = 1'b1;
            hold_n  = 1'b1;
            state_n = ST_ERR;
          end
`ifdef INSTR_LOADER_CHECK_EN
          else if (enc_illegal) begin
            ill_n   = 1'b1;
            hold_n  = 1'b1;
            state_n = ST_ERR;
          end
`endif
          else begin
            we_n    = 1'b1;
            addr_n  = BASE_ADDR + load_count[ADDR_W-1:0];
            data_n  = enc_word;
            count_n = load_count + (ADDR_W+1)'(1);
            if (in_last) state_n = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // First DONE cycle carries the final write; completion shows on the next one
        done_n  = 1'b1;
        hold_n  = 1'b0;
        restart = start;
      end
      ST_ERR: begin
        hold_n  = 1'b1;
        restart = start;
      end
      default: state_n = ST_IDLE;
    endcase
    if (restart) begin
      state_n = ST_LOAD;
      count_n = '0;
      addr_n  = BASE_ADDR;
      done_n  = 1'b0;
      ovf_n   = 1'b0;
      hold_n  = 1'b1;
`ifdef INSTR_LOADER_CHECK_EN
      ill_n   = 1'b0;
`endif
    end
    ready_n = (state_n == ST_LOAD);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      in_ready     <= 1'b0;
      we_q         <= 1'b0;
      imem_addr    <= BASE_ADDR;
      imem_data    <= '0;
      cpu_hold     <= 1'b1;
      load_done    <= 1'b0;
      load_count   <= '0;
      err_overflow <= 1'b0;
`ifdef INSTR_LOADER_CHECK_EN
      err_illegal  <= 1'b0;
`endif
    end else begin
      state        <= state_n;
      in_ready     <= ready_n;
      we_q         <= we_n;
      imem_addr    <= addr_n;
      imem_data    <= data_n;
      cpu_hold     <= hold_n;
      load_done    <= done_n;
      load_count   <= count_n;
      err_overflow <= ovf_n;
`ifdef INSTR_LOADER_CHECK_EN
      err_illegal  <= ill_n;
`endif
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: a 4K-word instance and a 4-word instance for overflow.
// Honours INSTR_LOADER_CHECK_EN for the unsupported-opcode case.
module tb_instr_loader;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        start, in_valid, in_last, s_start, s_valid, s_last;
  logic [4:0]  in_opcode, in_rd, in_rs, in_rt, in_shamt, in_aluop;
  logic [16:0] in_imm;
  logic [26:0] in_target;

  logic        in_ready, imem_we, cpu_hold, load_done, err_overflow;
  logic [11:0] imem_addr;
  logic [31:0] imem_data;
  logic [12:0] load_count;
  logic        s_ready, s_we, s_hold, s_done, s_ovf;
  logic [1:0]  s_addr;
  logic [31:0] s_data;
  logic [2:0]  s_count;
`ifdef INSTR_LOADER_CHECK_EN
  logic        err_illegal, s_illegal;
`endif

  instr_loader #(.ADDR_W(12)) dut (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_shamt(in_shamt),
    .in_aluop(in_aluop), .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_data(imem_data), .cpu_hold(cpu_hold),
    .load_done(load_done), .load_count(load_count), .err_overflow(err_overflow)
`ifdef INSTR_LOADER_CHECK_EN
    , .err_illegal(err_illegal)
`endif
  );

  instr_loader #(.ADDR_W(2)) dut_small (
    .clock(clock), .reset(reset), .start(s_start), .in_valid(s_valid), .in_ready(s_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_shamt(in_shamt),
    .in_aluop(in_aluop), .in_imm(in_imm), .in_target(in_target), .in_last(s_last),
    .imem_we(s_we), .imem_addr(s_addr), .imem_data(s_data), .cpu_hold(s_hold),
    .load_done(s_done), .load_count(s_count), .err_overflow(s_ovf)
`ifdef INSTR_LOADER_CHECK_EN
    , .err_illegal(s_illegal)
`endif
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t q_big[$];
  exp_t q_small[$];
  logic [4:0] legal_ops [11] = '{5'b00000, 5'b00101, 5'b00111, 5'b01000, 5'b00010, 5'b00110,
                                 5'b00001, 5'b00011, 5'b00100, 5'b10110, 5'b10101};

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_model(input logic [4:0] op, rd, rs, rt, sh, alu,
                                            input logic [16:0] imm, input logic [26:0] tgt);
    case (op)
      5'b00000:                                         return {op, rd, rs, rt, sh, alu, 2'b00};
      5'b00101, 5'b00111, 5'b01000, 5'b00010, 5'b00110: return {op, rd, rs, imm};
      5'b00100:                                         return {op, rd, 22'd0};
      default:                                          return {op, tgt};
    endcase
  endfunction

  // Write monitors: every imem write must match the oldest expected entry
  always @(negedge clock) begin : mon_big
    exp_t e;
    if (imem_we === 1'b1) begin
      if (q_big.size() == 0) chk("big_unexpected_we", 32'd1, 32'd0);
      else begin
        e = q_big.pop_front();
        chk("big_addr", 32'(imem_addr), e.addr);
        chk("big_data", imem_data, e.data);
        chk("big_latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  always @(negedge clock) begin : mon_small
    exp_t e;
    if (s_we === 1'b1) begin
      if (q_small.size() == 0) chk("small_unexpected_we", 32'd1, 32'd0);
      else begin
        e = q_small.pop_front();
        chk("small_addr", 32'(s_addr), e.addr);
        chk("small_data", s_data, e.data);
        chk("small_latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic send(input bit sel, input logic [4:0] op, rd, rs, rt, sh, alu,
                      input logic [16:0] imm, input logic [26:0] tgt, input bit last,
                      input bit expw, input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    @(negedge clock);
    in_opcode = op; in_rd = rd; in_rs = rs; in_rt = rt;
    in_shamt = sh; in_aluop = alu; in_imm = imm; in_target = tgt;
    if (sel) begin s_valid = 1'b1; s_last = last; end
    else     begin in_valid = 1'b1; in_last = last; end
    if (expw) begin
      e.addr = addr; e.data = data; e.cyc = cyc + 1;
      if (sel) q_small.push_back(e); else q_big.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clock);
    in_valid = 1'b0; in_last = 1'b0; s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic pulse_start(input bit sel);
    @(negedge clock);
    if (sel) s_start = 1'b1; else start = 1'b1;
    @(negedge clock);
    start = 1'b0; s_start = 1'b0;
  endtask

  initial begin
    logic [4:0]  op, rd, rs, rt, sh, alu;
    logic [16:0] imm;
    logic [26:0] tgt;
    logic [31:0] word;

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    s_start = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    in_opcode = '0; in_rd = '0; in_rs = '0; in_rt = '0; in_shamt = '0; in_aluop = '0;
    in_imm = '0; in_target = '0;
    repeat (3) @(negedge clock);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_imem_we", 32'(imem_we), 32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'd0);
    chk("rst_imem_data", imem_data, 32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_load_count", 32'(load_count), 32'd0);
    chk("rst_err_overflow", 32'(err_overflow), 32'd0);
    chk("rst_small_hold", 32'(s_hold), 32'd1);
`ifdef INSTR_LOADER_CHECK_EN
    chk("rst_err_illegal", 32'(err_illegal), 32'd0);
`endif
    reset = 1'b0;

    // Basic three-instruction session
    pulse_start(1'b0);
    chk("load_in_ready", 32'(in_ready), 32'd1);
    chk("load_cpu_hold", 32'(cpu_hold), 32'd1);
    send(1'b0, 5'b00000, 5'd1, 5'd2, 5'd3, 5'd0, 5'd0, 17'd0, 27'd0, 1'b0, 1'b1, 32'd0, 32'h00443000);
    send(1'b0, 5'b00101, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0, 17'h1FFFF, 27'd0, 1'b0, 1'b1, 32'd1, 32'h2901FFFF);
    send(1'b0, 5'b00001, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'h10, 1'b1, 1'b1, 32'd2, 32'h08000010);
    idle();
    chk("wrcyc_load_done", 32'(load_done), 32'd0);
    chk("wrcyc_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("wrcyc_load_count", 32'(load_count), 32'd3);
    @(negedge clock);
    chk("done_load_done", 32'(load_done), 32'd1);
    chk("done_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("done_load_count", 32'(load_count), 32'd3);
    chk("done_in_ready", 32'(in_ready), 32'd0);

    // Restart from DONE, then four back-to-back bundles
    pulse_start(1'b0);
    chk("restart_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("restart_load_done", 32'(load_done), 32'd0);
    chk("restart_load_count", 32'(load_count), 32'd0);
    send(1'b0, 5'b00100, 5'd31, 5'd7, 5'd9, 5'd3, 5'd5, 17'h155, 27'h5A5A5, 1'b0, 1'b1, 32'd0, 32'h27C00000);
    send(1'b0, 5'b00111, 5'd5, 5'd6, 5'd9, 5'd1, 5'd2, 17'd4, 27'h7FF, 1'b0, 1'b1, 32'd1, 32'h394C0004);
    for (int i = 0; i < 2; i++) begin
      op = legal_ops[$urandom_range(0, 10)];
      rd = 5'($urandom); rs = 5'($urandom); rt = 5'($urandom);
      sh = 5'($urandom); alu = 5'($urandom);
      imm = 17'($urandom); tgt = 27'($urandom);
      word = enc_model(op, rd, rs, rt, sh, alu, imm, tgt);
      send(1'b0, op, rd, rs, rt, sh, alu, imm, tgt, (i == 1), 1'b1, 32'(2 + i), word);
    end
    idle();
    @(negedge clock);
    chk("b2b_load_count", 32'(load_count), 32'd4);
    chk("b2b_load_done", 32'(load_done), 32'd1);

    // Unsupported opcode
    pulse_start(1'b0);
`ifdef INSTR_LOADER_CHECK_EN
    send(1'b0, 5'b11111, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'h123, 1'b1, 1'b0, 32'd0, 32'd0);
    idle();
    chk("illegal_flag", 32'(err_illegal), 32'd1);
    chk("illegal_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("illegal_in_ready", 32'(in_ready), 32'd0);
    chk("illegal_load_count", 32'(load_count), 32'd0);
`else
    send(1'b0, 5'b11111, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'h123, 1'b1, 1'b1, 32'd0, 32'hF8000123);
    idle();
    @(negedge clock);
    chk("unlisted_load_done", 32'(load_done), 32'd1);
    chk("unlisted_load_count", 32'(load_count), 32'd1);
`endif

    // Reset in the cycle after an accept drops the write
    pulse_start(1'b0);
    send(1'b0, 5'b00101, 5'd3, 5'd2, 5'd0, 5'd0, 5'd0, 17'h0ABC, 27'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clock);
    #1 reset = 1'b1; in_valid = 1'b0;
    @(negedge clock);
    chk("abort_imem_we", 32'(imem_we), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    chk("abort_imem_addr", 32'(imem_addr), 32'd0);
    chk("abort_imem_data", imem_data, 32'd0);
    chk("abort_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("abort_load_count", 32'(load_count), 32'd0);
    chk("abort_imem_we2", 32'(imem_we), 32'd0);

    // Four-word memory: fifth accept overflows
    pulse_start(1'b1);
    for (int i = 0; i < 5; i++) begin
      op = legal_ops[$urandom_range(0, 10)];
      rd = 5'($urandom); rs = 5'($urandom); rt = 5'($urandom);
      sh = 5'($urandom); alu = 5'($urandom);
      imm = 17'($urandom); tgt = 27'($urandom);
      word = enc_model(op, rd, rs, rt, sh, alu, imm, tgt);
      send(1'b1, op, rd, rs, rt, sh, alu, imm, tgt, 1'b0, (i < 4), 32'(i), word);
    end
    idle();
    chk("ovf_flag", 32'(s_ovf), 32'd1);
    chk("ovf_cpu_hold", 32'(s_hold), 32'd1);
    chk("ovf_in_ready", 32'(s_ready), 32'd0);
    chk("ovf_load_count", 32'(s_count), 32'd4);
    chk("ovf_load_done", 32'(s_done), 32'd0);
    @(negedge clock);
    chk("ovf_sticky", 32'(s_ovf), 32'd1);
    pulse_start(1'b1);
    chk("ovf_restart_flag", 32'(s_ovf), 32'd0);
    chk("ovf_restart_count", 32'(s_count), 32'd0);
    chk("ovf_restart_ready", 32'(s_ready), 32'd1);

    repeat (3) @(negedge clock);
    chk("big_queue_empty", 32'(q_big.size()), 32'd0);
    chk("small_queue_empty", 32'(q_small.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
